prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker_if.sv | 31 +++
 rtl/prbs_checker.sv | 160 ++++++++++++++++
 tb/tb_prbs_checker.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_checker_if.sv
// rtl/prbs_checker_if.sv - beat input, counter clear and status bundle for prbs_checker
// Ports (signals):
//   s_valid  : beat qualifier
//   s_data   : received PRBS bits, bit 0 oldest
//   clr_cnt  : synchronous clear of err_cnt/beat_cnt
//   locked   : lock status
//   err_beat : one-cycle pulse per errored beat while locked
//   err_cnt  : accumulated bit errors (saturating)
//   beat_cnt : locked beats checked
// Modports: master drives the beat side, slave is the checker.
interface prbs_checker_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  clr_cnt;
  logic                  locked;
  logic                  err_beat;
  logic [31:0]           err_cnt;
  logic [47:0]           beat_cnt;

  modport master (
    output s_valid, s_data, clr_cnt,
    input  locked, err_beat, err_cnt, beat_cnt
  );

  modport slave (
    input  s_valid, s_data, clr_cnt,
    output locked, err_beat, err_cnt, beat_cnt
  );
endinterface

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - PRBS receive checker with self-synchronising lock
// Ports:
//   clk : single clock
//   rst : synchronous active-high reset
//   bus : prbs_checker_if.slave (s_valid, s_data, clr_cnt in; locked, err_beat,
//         err_cnt, beat_cnt out)
// Optional feature macro: PRBS_CHECKER_BEAT_CNT_EN enables the locked-beat counter;
// without it beat_cnt is tied to 0.
package lfsr_pkg;
  // x^7 + x^6 + 1 as a right-shifting Galois toggle mask, bit index = tap
  localparam logic [7:1] PRBS7 = 7'b1100000;
endpackage

module prbs_checker #(
  parameter int                    POLY_DEGREE  = 7,
  parameter logic [POLY_DEGREE:1]  POLYNOMIAL   = lfsr_pkg::PRBS7,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    LOCK_COUNT   = 16,
  parameter int                    UNLOCK_COUNT = 4
) (
  input  logic           clk,
  input  logic           rst,
  prbs_checker_if.slave  bus
);

  localparam int PC_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [POLY_DEGREE:1]  lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] expected;
  logic [DATA_WIDTH-1:0] mismatch;
  logic [PC_W-1:0]       n_err;
  logic [7:0]            clean_q, clean_d;
  logic [7:0]            bad_q, bad_d;
  logic                  err_beat_q, err_beat_d;
  logic [31:0]           err_cnt_q;
  logic [32:0]           err_sum;
  logic                  count_en;

  // Step the Galois LFSR once per bit. While searching, the received bit is
  // fed back so the state is rebuilt from the line after POLY_DEGREE good
  // bits; once locked, the local prediction is fed back so line errors do
  // not corrupt the reference.
  always_comb begin
    logic [POLY_DEGREE:1] s;
    logic                 fb;
    s        = lfsr_q;
    fb       = 1'b0;
    expected = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      expected[i] = s[1];
      fb          = (fsm_q == LOCKED) ? s[1] : bus.s_data[i];
      s           = (s >> 1) ^ (fb ? POLYNOMIAL : '0);
    end
    lfsr_d = s;
  end

  assign mismatch = bus.s_data ^ expected;

  always_comb begin
    n_err = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      n_err = n_err + PC_W'(mismatch[i]);
    end
  end

  assign count_en = bus.s_valid && (fsm_q == LOCKED);
  assign err_sum  = {1'b0, err_cnt_q} + 33'(n_err);

  always_comb begin
    fsm_d      = fsm_q;
    clean_d    = clean_q;
    bad_d      = bad_q;
    err_beat_d = 1'b0;
    if (bus.s_valid) begin
      case (fsm_q)
        SEARCH: begin
          // An all-zero state predicts all zeros and would "match" a dead line
          if ((mismatch == '0) && (lfsr_q != '0)) begin
            if (clean_q == 8'(LOCK_COUNT - 1)) begin
              fsm_d   = LOCKED;
              clean_d = '0;
            end else begin
              clean_d = clean_q + 8'd1;
            end
          end else begin
            clean_d = '0;
          end
        end
        LOCKED: begin
          if (mismatch != '0) begin
            err_beat_d = 1'b1;
            if (bad_q == 8'(UNLOCK_COUNT - 1)) begin
              fsm_d   = SEARCH;
              bad_d   = '0;
              clean_d = '0;
            end else begin
              bad_d = bad_q + 8'd1;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: fsm_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= SEARCH;
      lfsr_q     <= '0;
      clean_q    <= '0;
      bad_q      <= '0;
      err_beat_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      fsm_q      <= fsm_d;
      clean_q    <= clean_d;
      bad_q      <= bad_d;
      err_beat_q <= err_beat_d;
      if (bus.s_valid) begin
        lfsr_q <= lfsr_d;
      end
      if (bus.clr_cnt) begin
        err_cnt_q <= '0;
      end else if (count_en) begin
        err_cnt_q <= err_sum[32] ? '1 : err_sum[31:0];
      end
    end
  end

`ifdef PRBS_CHECKER_BEAT_CNT_EN
  logic [47:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      beat_cnt_q <= '0;
    end else if (count_en) begin
      beat_cnt_q <= beat_cnt_q + 48'd1;
    end
  end

  assign bus.beat_cnt = beat_cnt_q;
`else
  assign bus.beat_cnt = '0;
`endif

  assign bus.locked   = (fsm_q == LOCKED);
  assign bus.err_beat = err_beat_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - scoreboard bench for prbs_checker against a beat-level model
module tb_prbs_checker;

  localparam int     DW           = 8;
  localparam int     POLY         = 'h60;
  localparam int     LOCK_COUNT   = 16;
  localparam int     UNLOCK_COUNT = 4;
  localparam longint ERR_MAX      = 64'h0000_0000_FFFF_FFFF;
  localparam longint BEAT_MOD     = 64'h0001_0000_0000_0000;

  typedef struct packed {
    logic        locked;
    logic        err_beat;
    logic [31:0] err_cnt;
    logic [47:0] beat_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  prbs_checker_if #(.DATA_WIDTH(DW)) bus ();

  prbs_checker #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  // Reference model state
  int     m_lfsr;
  int     m_clean;
  int     m_bad;
  bit     m_locked;
  longint m_err;
  longint m_beat;
  int     g_state;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_lfsr   = 0;
    m_clean  = 0;
    m_bad    = 0;
    m_locked = 0;
    m_err    = 0;
    m_beat   = 0;
  endfunction

  // Predicts outputs after one valid beat, working beat-at-a-time on integers
  function automatic exp_t model_beat(input logic [7:0] d, input bit clr);
    int       s0, expb, o, fb, nerr;
    bit       eb;
    bit [7:0] diff;
    exp_t     e;
    s0   = m_lfsr;
    expb = 0;
    for (int i = 0; i < DW; i++) begin
      o      = m_lfsr & 1;
      expb   = expb | (o << i);
      fb     = m_locked ? o : int'(d[i]);
      m_lfsr = (m_lfsr >> 1) ^ (fb != 0 ? POLY : 0);
    end
    diff = d ^ expb[7:0];
    nerr = $countones(diff);
    eb   = 1'b0;
    if (!m_locked) begin
      if (diff == 0 && s0 != 0) begin
        m_clean++;
        if (m_clean == LOCK_COUNT) begin
          m_locked = 1;
          m_clean  = 0;
        end
      end else begin
        m_clean = 0;
      end
    end else begin
      eb = (diff != 0);
      if (!clr) begin
        m_err = (m_err + nerr > ERR_MAX) ? ERR_MAX : m_err + nerr;
`ifdef PRBS_CHECKER_BEAT_CNT_EN
        m_beat = (m_beat + 1) % BEAT_MOD;
`endif
      end
      if (diff != 0) begin
        m_bad++;
        if (m_bad == UNLOCK_COUNT) begin
          m_locked = 0;
          m_bad    = 0;
          m_clean  = 0;
        end
      end else begin
        m_bad = 0;
      end
    end
    if (clr) begin
      m_err  = 0;
      m_beat = 0;
    end
    e.locked   = m_locked;
    e.err_beat = eb;
    e.err_cnt  = m_err[31:0];
    e.beat_cnt = m_beat[47:0];
    return e;
  endfunction

  // Transmitter-side PRBS7 source, independent of the receiver model
  function automatic logic [7:0] gen_byte();
    logic [7:0] d;
    int         o;
    d = '0;
    for (int i = 0; i < DW; i++) begin
      o       = g_state & 1;
      d[i]    = o[0];
      g_state = (g_state >> 1) ^ (o != 0 ? POLY : 0);
    end
    return d;
  endfunction

  task automatic cycle(input bit v, input logic [7:0] d, input bit c);
    @(negedge clk);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.clr_cnt = c;
    if (v) sb_q.push_back(model_beat(d, c));
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.s_valid = 1'($urandom_range(0, 1));
    bus.s_data  = 8'($urandom);
    bus.clr_cnt = 1'($urandom_range(0, 1));
    model_reset();
    @(negedge clk);
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    bus.clr_cnt = 1'b0;
  endtask

  // Monitor: every edge, pop on a valid beat, otherwise outputs must hold
  initial begin
    exp_t e;
    logic v, r;
    e = '0;
    forever begin
      @(posedge clk);
      v = bus.s_valid;
      r = rst;
      #1;
      if (r) begin
        e = '0;
      end else if (v) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
        end
      end else begin
        e.err_beat = 1'b0;
      end
      chk("mon_locked",   64'(bus.locked),   64'(e.locked));
      chk("mon_err_beat", 64'(bus.err_beat), 64'(e.err_beat));
      chk("mon_err_cnt",  64'(bus.err_cnt),  64'(e.err_cnt));
      chk("mon_beat_cnt", 64'(bus.beat_cnt), 64'(e.beat_cnt));
    end
  end

  initial begin
    int nvalid, lock_at, burst;
    logic [7:0] d;
    bit c;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.clr_cnt = 1'b0;
    model_reset();
    do_reset();

    // Clean gapless stream: first beat is never clean (zero state), lock after 16 more
    g_state = 'h5A;
    for (int k = 1; k <= 17; k++) begin
      cycle(1'b1, gen_byte(), 1'b0);
      if (k == 16) chk("s1_locked_before", 64'(bus.locked), 64'd0);
      if (k == 17) chk("s1_locked_after",  64'(bus.locked), 64'd1);
    end
    chk("s1_err_cnt", 64'(bus.err_cnt), 64'd0);

    // Single bit-3 error while locked
    cycle(1'b1, gen_byte() ^ 8'h08, 1'b0);
    chk("s2_err_beat", 64'(bus.err_beat), 64'd1);
    chk("s2_err_cnt",  64'(bus.err_cnt),  64'd1);
    chk("s2_locked",   64'(bus.locked),   64'd1);
    cycle(1'b1, gen_byte(), 1'b0);
    chk("s2_err_beat_clear", 64'(bus.err_beat), 64'd0);

    // Four 2-bit errored beats drop lock; relock after 16 clean beats
    cycle(1'b1, gen_byte(), 1'b1);
    chk("s3_clr", 64'(bus.err_cnt), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, gen_byte() ^ 8'h21, 1'b0);
      chk("s3_err_beat", 64'(bus.err_beat), 64'd1);
      chk("s3_locked",   64'(bus.locked),   (k < 4) ? 64'd1 : 64'd0);
    end
    chk("s3_err_cnt", 64'(bus.err_cnt), 64'd8);
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, gen_byte(), 1'b0);
      if (k == 15) chk("s3_relock_before", 64'(bus.locked), 64'd0);
      if (k == 16) chk("s3_relock_after",  64'(bus.locked), 64'd1);
    end
    chk("s3_err_cnt_kept", 64'(bus.err_cnt), 64'd8);

    // clr_cnt on an errored beat, then reset while locked
    cycle(1'b1, gen_byte() ^ 8'h08, 1'b1);
    chk("s6_clr_err_cnt", 64'(bus.err_cnt), 64'd0);
    chk("s6_clr_locked",  64'(bus.locked),  64'd1);
    do_reset();
    chk("s6_rst_locked",   64'(bus.locked),   64'd0);
    chk("s6_rst_err_cnt",  64'(bus.err_cnt),  64'd0);
    chk("s6_rst_beat_cnt", 64'(bus.beat_cnt), 64'd0);

    // All-zero line never locks
    for (int k = 0; k < 100; k++) cycle(1'b1, 8'h00, 1'b0);
    chk("s4_zero_locked", 64'(bus.locked), 64'd0);

    // 50% gaps: lock still on the 17th valid beat
    do_reset();
    g_state = 'h33;
    nvalid  = 0;
    lock_at = 0;
    for (int k = 0; k < 400 && nvalid < 20; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        cycle(1'b1, gen_byte(), 1'b0);
        nvalid++;
        if (bus.locked && lock_at == 0) lock_at = nvalid;
      end else begin
        cycle(1'b0, 8'($urandom), 1'b0);
      end
    end
    chk("s5_lock_beat", 64'(lock_at), 64'd17);

    // Random traffic with error bursts and occasional clears
    do_reset();
    g_state = 'h11;
    burst   = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        d = gen_byte();
        if (burst > 0) begin
          d = d ^ 8'($urandom_range(1, 255));
          burst--;
        end else if ($urandom_range(0, 15) == 0) begin
          d = d ^ 8'($urandom_range(1, 255));
        end
        if ($urandom_range(0, 79) == 0) burst = $urandom_range(1, 6);
        c = ($urandom_range(0, 39) == 0);
        cycle(1'b1, d, c);
      end else begin
        cycle(1'b0, 8'($urandom), 1'b0);
      end
    end

    cycle(1'b0, 8'h00, 1'b0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
